// File: rtl/cic_pkg.sv
// Shared CIC constants and the round-then-shift helper used by the comb scale stage.
package cic_pkg;

   localparam int CIC_ORDER = 5;
   localparam int CIC_WIDTH = 30;
   localparam int CIC_OUT_W = 16;

   // Adds half an LSB of the shifted result, then shifts arithmetically; one guard bit avoids overflow.
   function automatic logic signed [CIC_WIDTH:0] round_shift(
      input logic signed [CIC_WIDTH-1:0] value,
      input logic [4:0]                  shift
   );
      logic signed [CIC_WIDTH:0] bias;
      logic signed [CIC_WIDTH:0] s;
      bias = (shift == 5'd0) ? '0 : ((CIC_WIDTH+1)'(1) <<< (shift - 5'd1));
      s    = {value[CIC_WIDTH-1], value};
      s    = s + bias;
      return s >>> shift;
   endfunction

endpackage

// File: rtl/cic_comb_decim_if.sv
// Sample-path bundle for the CIC comb section; sat_hit exists only with CIC_COMB_SAT_EN.
interface cic_comb_decim_if
   import cic_pkg::*;
#(
   parameter int WIDTH = CIC_WIDTH,
   parameter int OUT_W = CIC_OUT_W
);
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic [4:0]       out_shift;
   logic             out_valid;
   logic [OUT_W-1:0] out_data;
   logic             out_ready;
   logic             overflow;
   logic             clr_ovf;
`ifdef CIC_COMB_SAT_EN
   logic             sat_hit;

   modport master (
      output in_valid, in_data, out_shift, out_ready, clr_ovf,
      input  out_valid, out_data, overflow, sat_hit
   );
   modport slave (
      input  in_valid, in_data, out_shift, out_ready, clr_ovf,
      output out_valid, out_data, overflow, sat_hit
   );
`else
   modport master (
      output in_valid, in_data, out_shift, out_ready, clr_ovf,
      input  out_valid, out_data, overflow
   );
   modport slave (
      input  in_valid, in_data, out_shift, out_ready, clr_ovf,
      output out_valid, out_data, overflow
   );
`endif
endinterface

// File: rtl/cic_comb_stage.sv
// One CIC comb: y = x - x[n-M] modulo 2^WIDTH, advancing only on in_valid.
module cic_comb_stage #(
   parameter int WIDTH      = 30,
   parameter int DIFF_DELAY = 1
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data
);

   // Newest sample sits in the low word; the tap is the oldest word.
   logic [DIFF_DELAY*WIDTH-1:0] dly_q, dly_d;
   logic [WIDTH-1:0]            data_q, data_d;
   logic                        valid_q, valid_d;

   always_comb begin
      dly_d   = dly_q;
      data_d  = data_q;
      valid_d = in_valid;
      if (in_valid) begin
         data_d = in_data - dly_q[DIFF_DELAY*WIDTH-1 -: WIDTH];
         dly_d  = (DIFF_DELAY*WIDTH)'({dly_q, in_data});
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dly_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         dly_q   <= dly_d;
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;

endmodule

// File: rtl/cic_comb_decim.sv
// CIC decimator comb section: ORDER pipelined combs, round/shift to OUT_W, 2-entry output FIFO.
// Define CIC_COMB_SAT_EN to clamp instead of wrap and to expose the sticky sat_hit flag.
module cic_comb_decim
   import cic_pkg::*;
#(
   parameter int WIDTH      = CIC_WIDTH,
   parameter int ORDER      = CIC_ORDER,
   parameter int DIFF_DELAY = 1,
   parameter int OUT_W      = CIC_OUT_W
)(
   input logic              clk,
   input logic              rst,
   cic_comb_decim_if.slave  bus
);

   logic             stg_valid [ORDER+1];
   logic [WIDTH-1:0] stg_data  [ORDER+1];

   assign stg_valid[0] = bus.in_valid;
   assign stg_data[0]  = bus.in_data;

   for (genvar k = 0; k < ORDER; k++) begin : g_comb
      cic_comb_stage #(
         .WIDTH      (WIDTH),
         .DIFF_DELAY (DIFF_DELAY)
      ) u_stage (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (stg_valid[k]),
         .in_data   (stg_data[k]),
         .out_valid (stg_valid[k+1]),
         .out_data  (stg_data[k+1])
      );
   end

   logic signed [WIDTH:0] rs;
   logic [OUT_W-1:0]      scaled;
`ifdef CIC_COMB_SAT_EN
   localparam logic signed [WIDTH:0] SAT_HI = (WIDTH+1)'((1 << (OUT_W-1)) - 1);
   localparam logic signed [WIDTH:0] SAT_LO = (WIDTH+1)'(-(1 << (OUT_W-1)));
   logic clamp;
   logic sat_hit_q, sat_hit_d;
`endif

   always_comb begin
      rs = round_shift(stg_data[ORDER], bus.out_shift);
`ifdef CIC_COMB_SAT_EN
      clamp  = 1'b1;
      if (rs > SAT_HI)      scaled = OUT_W'(SAT_HI);
      else if (rs < SAT_LO) scaled = OUT_W'(SAT_LO);
      else begin
         scaled = OUT_W'(rs);
         clamp  = 1'b0;
      end
      sat_hit_d = bus.clr_ovf ? 1'b0 : sat_hit_q;
      if (stg_valid[ORDER] && clamp) sat_hit_d = 1'b1;
`else
      scaled = OUT_W'(rs);
`endif
   end

   logic             scale_valid_q, scale_valid_d;
   logic [OUT_W-1:0] scale_data_q, scale_data_d;
   logic [OUT_W-1:0] mem_q [2];
   logic [OUT_W-1:0] mem_d [2];
   logic             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [1:0]       count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             pop, accept;

   // A full FIFO still accepts when the head leaves in the same cycle.
   always_comb begin
      scale_valid_d = stg_valid[ORDER];
      scale_data_d  = stg_valid[ORDER] ? scaled : scale_data_q;
      mem_d         = mem_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      pop           = (count_q != 2'd0) && bus.out_ready;
      accept        = scale_valid_q && ((count_q != 2'd2) || pop);
      ovf_d         = bus.clr_ovf ? 1'b0 : ovf_q;
      if (scale_valid_q && !accept) ovf_d = 1'b1;
      if (pop) rd_ptr_d = ~rd_ptr_q;
      if (accept) begin
         mem_d[wr_ptr_q] = scale_data_q;
         wr_ptr_d        = ~wr_ptr_q;
      end
      count_d = count_q + {1'b0, accept} - {1'b0, pop};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         scale_valid_q <= 1'b0;
         scale_data_q  <= '0;
         mem_q         <= '{default: '0};
         wr_ptr_q      <= 1'b0;
         rd_ptr_q      <= 1'b0;
         count_q       <= 2'd0;
         ovf_q         <= 1'b0;
      end else begin
         scale_valid_q <= scale_valid_d;
         scale_data_q  <= scale_data_d;
         mem_q         <= mem_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         ovf_q         <= ovf_d;
      end
   end

`ifdef CIC_COMB_SAT_EN
   always_ff @(posedge clk) begin
      if (rst) sat_hit_q <= 1'b0;
      else     sat_hit_q <= sat_hit_d;
   end
   assign bus.sat_hit = sat_hit_q;
`endif

   assign bus.out_valid = (count_q != 2'd0);
   assign bus.out_data  = mem_q[rd_ptr_q];
   assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_cic_comb_decim.sv
// Bench for cic_comb_decim: impulse table, wrap, back-pressure, reset, and random traffic vs a
// binomial-sum reference with a queue-based FIFO model.
module tb_cic_comb_decim;
   import cic_pkg::*;

   localparam int M = 1;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cic_comb_decim_if bus ();

   cic_comb_decim #(
      .WIDTH      (CIC_WIDTH),
      .ORDER      (CIC_ORDER),
      .DIFF_DELAY (M),
      .OUT_W      (CIC_OUT_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Reference: output n = sum_k (-1)^k C(5,k) x[n-kM] mod 2^30, then round/shift, then wrap or clamp.
   typedef struct { logic [15:0] val; bit sat; int cnt; } pend_t;
   longint      xh[$];
   pend_t       pend[$];
   logic [15:0] fq[$];
   bit          m_ovf, m_sat;
   logic [15:0] got[$];

   task automatic model_sample(input logic [4:0] sh, output logic [15:0] v, output bit s);
      int     c[6] = '{1, -5, 10, -10, 5, -1};
      longint acc = 0;
      logic signed [CIC_WIDTH-1:0] y;
      logic signed [CIC_WIDTH:0]   r;
      for (int k = 0; k < 6; k++)
         if (k*M < xh.size()) acc += longint'(c[k]) * xh[k*M];
      y = acc[CIC_WIDTH-1:0];
      r = round_shift(y, sh);
      s = 1'b0;
      v = r[15:0];
`ifdef CIC_COMB_SAT_EN
      if (r > 32767)       begin v = 16'h7FFF; s = 1'b1; end
      else if (r < -32768) begin v = 16'h8000; s = 1'b1; end
`endif
   endtask

   task automatic model_edge(input bit r, input bit iv, input logic [29:0] d, input bit rdy,
                             input bit clr, input logic [4:0] sh);
      int    sz;
      bit    pop;
      pend_t p;
      if (r) begin
         xh.delete(); pend.delete(); fq.delete();
         m_ovf = 0; m_sat = 0;
         return;
      end
      sz  = fq.size();
      pop = (sz > 0) && rdy;
      if (clr) begin m_ovf = 0; m_sat = 0; end
      foreach (pend[i]) begin
         pend[i].cnt--;
         if (pend[i].cnt == 1 && pend[i].sat) m_sat = 1;
      end
      if (pop) void'(fq.pop_front());
      if (pend.size() > 0 && pend[0].cnt == 0) begin
         p = pend.pop_front();
         if (sz == 2 && !pop) m_ovf = 1;
         else fq.push_back(p.val);
      end
      if (iv) begin
         xh.push_front(longint'(d));
         if (xh.size() > 16) void'(xh.pop_back());
         model_sample(sh, p.val, p.sat);
         p.cnt = 6;
         pend.push_back(p);
      end
   endtask

   task automatic step(input bit r, input bit iv, input logic [29:0] d, input bit rdy, input bit clr);
      rst = r; bus.in_valid = iv; bus.in_data = d; bus.out_ready = rdy; bus.clr_ovf = clr;
      if (bus.out_valid && rdy && !r) got.push_back(bus.out_data);
      @(posedge clk);
      model_edge(r, iv, d, rdy, clr, bus.out_shift);
      #1;
      chk("out_valid", bus.out_valid, 32'(fq.size() > 0));
      if (fq.size() > 0) chk("out_data", bus.out_data, fq[0]);
      chk("overflow", bus.overflow, m_ovf);
`ifdef CIC_COMB_SAT_EN
      chk("sat_hit", bus.sat_hit, m_sat);
`endif
   endtask

   typedef struct { logic [29:0] amp; logic [4:0] sh; logic [15:0] exp [8]; string name; } vec_t;
   vec_t tbl [3];

   task automatic run_impulse(input vec_t v, input bit do_reset);
      int first_k = -1;
      if (do_reset) begin
         step(1, 0, '0, 1, 0);
         step(0, 0, '0, 1, 0);
      end
      bus.out_shift = v.sh;
      got.delete();
      for (int k = 1; k <= 20; k++) begin
         step(0, k <= 8, (k == 1) ? v.amp : 30'd0, 1, 0);
         if (first_k < 0 && bus.out_valid) first_k = k;
      end
      chk({v.name, "_latency"}, 32'(first_k), 32'd7);
      chk({v.name, "_count"}, 32'(got.size()), 32'd8);
      for (int i = 0; i < 8; i++)
         if (i < got.size()) chk($sformatf("%s_s%0d", v.name, i), got[i], v.exp[i]);
   endtask

   initial begin
      tbl[0] = '{amp: 30'd1, sh: 5'd0, name: "impulse",
                 exp: '{16'h0001, 16'hFFFB, 16'h000A, 16'hFFF6, 16'h0005, 16'hFFFF, 16'h0000, 16'h0000}};
      tbl[1] = '{amp: 30'd256, sh: 5'd4, name: "round",
                 exp: '{16'h0010, 16'hFFB0, 16'h00A0, 16'hFF60, 16'h0050, 16'hFFF0, 16'h0000, 16'h0000}};
`ifdef CIC_COMB_SAT_EN
      tbl[2] = '{amp: 30'h100000, sh: 5'd0, name: "sat",
                 exp: '{16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 16'h0000, 16'h0000}};
`else
      tbl[2] = '{amp: 30'h100000, sh: 5'd0, name: "sat",
                 exp: '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000}};
`endif
      bus.out_shift = 5'd0;

      // Reset state
      step(1, 0, '0, 1, 0);
      step(1, 0, '0, 1, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_data", bus.out_data, 0);
      chk("rst_overflow", bus.overflow, 0);

      // Impulse / rounding / saturation table
      for (int i = 0; i < 3; i++) begin
         run_impulse(tbl[i], 1'b1);
`ifdef CIC_COMB_SAT_EN
         if (i == 2) chk("sat_hit_set", bus.sat_hit, 1);
`endif
      end

      // Stage-1 wrap
      bus.out_shift = 5'd0;
      step(1, 0, '0, 1, 0);
      step(0, 1, 30'h3FFFFFFF, 1, 0);
      chk("wrap_c1_a", dut.g_comb[0].u_stage.data_q, 32'h3FFFFFFF);
      step(0, 1, 30'h00000004, 1, 0);
      chk("wrap_c1_b", dut.g_comb[0].u_stage.data_q, 32'h5);
      for (int k = 0; k < 12; k++) step(0, 0, '0, 1, 0);

      // Back-pressure: 4 strobes, no drain
      step(1, 0, '0, 0, 0);
      for (int k = 1; k <= 4; k++) step(0, 1, 30'(k), 0, 0);
      for (int k = 0; k < 8; k++) step(0, 0, '0, 0, 0);
      chk("bp_valid", bus.out_valid, 1);
      chk("bp_head", bus.out_data, 16'h0001);
      chk("bp_overflow", bus.overflow, 1);
      got.delete();
      for (int k = 0; k < 4; k++) step(0, 0, '0, 1, 0);
      chk("bp_drain_cnt", 32'(got.size()), 2);
      if (got.size() == 2) begin
         chk("bp_drain_0", got[0], 16'h0001);
         chk("bp_drain_1", got[1], 16'hFFFD);
      end
      chk("bp_ovf_hold", bus.overflow, 1);
      step(0, 0, '0, 1, 1);
      chk("bp_clr_ovf", bus.overflow, 0);

      // Reset mid-stream, then the impulse must repeat exactly
      step(1, 0, '0, 1, 0);
      got.delete();
      step(0, 1, 30'd1, 1, 0);
      for (int k = 0; k < 20 && got.size() < 3; k++) step(0, 1, 30'd0, 1, 0);
      chk("mid_got3", 32'(got.size()), 3);
      step(1, 0, '0, 1, 0);
      chk("mid_rst_valid", bus.out_valid, 0);
      run_impulse(tbl[0], 1'b0);

      // Randomized traffic
      step(1, 0, '0, 1, 0);
      for (int seg = 0; seg < 6; seg++) begin
         for (int k = 0; k < 8; k++) step(0, 0, '0, 1, 0);
         bus.out_shift = 5'($urandom_range(0, 14));
         for (int k = 0; k < 120; k++)
            step(0, $urandom_range(0, 3) != 0, 30'($urandom), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 15) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cic_comb_decim.md
Name: cic_comb_decim

Overview:
Comb section of the 5th-order CIC decimator. It runs at the input clock but advances only on a decimated-rate valid strobe from the integrator stage, which supplies its Int5 value on that strobe. Five pipelined comb (differentiator) stages remove the integrator growth, then a programmable shift-and-round reduces the result to 16 bits. Results pass to the downstream compensation FIR through a 2-entry output FIFO with a valid/ready interface.

Parameters:
WIDTH, 30, integrator/comb word width (two's complement, modulo 2^WIDTH)
ORDER, 5, number of comb stages; must equal the integrator order
DIFF_DELAY, 1, differential delay M per comb, legal values 1 or 2
OUT_W, 16, output sample width

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  decimated-rate strobe, one cycle per output sample; may be high every cycle
in_data  in  WIDTH  Int5 value sampled when in_valid=1
out_shift  in  5  arithmetic right shift before truncation, 0..WIDTH-OUT_W; quasi-static
out_valid  out  1  FIFO head holds a sample
out_data  out  OUT_W  FIFO head sample
out_ready  in  1  downstream accepts the head when out_valid & out_ready
overflow  out  1  sticky; a finished sample was dropped because the FIFO was full
clr_ovf  in  1  clears overflow; a same-cycle drop wins and keeps it set

Behaviour:
- Reset: all comb delay registers, stage valids, FIFO pointers/count and overflow are 0. out_valid=0, out_data=0.
- Stage k (1..ORDER): on its input valid, y_k = x_k - x_k[n-M] mod 2^WIDTH. The delay line shifts only on valid. Registered output; the valid bit propagates with the data. Stage 1 input is in_data.
- Arithmetic wraps modulo 2^WIDTH with no saturation inside the combs. Integrator wrap is therefore cancelled exactly.
- Scale stage (registered): s = comb_out + (out_shift>0 ? 2^(out_shift-1) : 0), computed in WIDTH+1 bits. Then s >>> out_shift (arithmetic). The result is the low OUT_W bits, or saturated when CIC_COMB_SAT_EN is defined.
- Latency: in_valid in cycle t gives comb output valid in cycle t+ORDER (t+5) and scale register valid in t+6. It is written to the FIFO at the end of t+6. out_valid rises in t+7 if the FIFO was empty. Fixed 7 cycles; no bubbles.
- Throughput: one sample per cycle sustained when out_ready=1.
- FIFO: 2 entries; out_data always shows the head. Pop on out_valid & out_ready.
- Simultaneous push and pop when full: both occur and no drop. Push when full without pop: sample discarded, overflow set.
- The pipeline never stalls; in_valid has no ready. Back-pressure only causes drops.
- out_shift change mid-stream takes effect on the next sample entering the scale stage.
- rst mid-operation clears everything in the next cycle, including FIFO contents; comb history restarts from zero.

Optional Feature:
CIC_COMB_SAT_EN defined: the scaled value is clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. When clamping occurs, sat_hit (extra 1-bit output port, sticky, cleared by clr_ovf) is set.
Undefined: plain truncation to the low OUT_W bits with wrap, and no sat_hit port.

Decomposition:
- Package cic_pkg holds the constants CIC_ORDER=5, CIC_WIDTH=30 and CIC_OUT_W=16, shared with the integrator block.
- cic_pkg also holds a function round_shift(value, shift) used by the scale stage and the testbench model.
- Sub-module cic_comb_stage (WIDTH, DIFF_DELAY): one comb with its delay line and valid register, instantiated ORDER times.
- The FIFO is inline.

Test Plan:
1. Impulse: M=1, shift 0, out_ready=1; in_data 1 then zeros on 8 strobes -> out_data 0x0001,0xFFFB,0x000A,0xFFF6,0x0005,0xFFFF,0x0000,0x0000; first out_valid 7 cycles after first strobe.
2. Wrap: strobes 0x3FFFFFFF, 0x00000004 with stages 2..5 history zero (check stage-1 output) -> comb1 outputs -1 then 5.
3. Scale/round: impulse 256, shift 4 -> 16,-80,160,-160,80,-16.
4. Saturation: impulse 0x100000, shift 0 -> with CIC_COMB_SAT_EN first output 0x7FFF and sat_hit=1; without it 0x0000.
5. Back-pressure: out_ready=0, 4 consecutive strobes -> FIFO holds samples 1,2 and overflow=1; out_ready=1 drains them in order; clr_ovf clears overflow.
6. Reset mid-stream: rst for 1 cycle after 3 impulse-response samples -> out_valid=0 next cycle; a new impulse reproduces scenario 1 exactly.
